// File: rtl/gate_pkg.sv
// Shared definitions for 2-input gate exercisers: gate opcodes, sequencer states
// and the reference truth function used for checking.
package gate_pkg;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_XOR  = 2;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XNOR = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Unknown opcodes fall back to OR.
   function automatic logic gate_expect(input int op, input logic a, input logic b);
      case (op)
         GATE_AND:  return a & b;
         GATE_OR:   return a | b;
         GATE_XOR:  return a ^ b;
         GATE_NAND: return ~(a & b);
         GATE_NOR:  return ~(a | b);
         GATE_XNOR: return ~(a ^ b);
         default:   return a | b;
      endcase
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for a 2-input gate: exp_y = f(GATE_OP, a, b).
module gate_ref_model
   import gate_pkg::*;
#(
   parameter int GATE_OP = GATE_OR
) (
   input  logic a,
   input  logic b,
   output logic exp_y
);

   assign exp_y = gate_expect(GATE_OP, a, b);

endmodule

// File: rtl/gate_exerciser.sv
// Clocked exhaustive a/b sequencer for a 2-input gate DUT, checking y per vector.
// Optional first-failure capture on fail_vec: GATE_EXERCISER_FAIL_CAPTURE_EN.
module gate_exerciser
   import gate_pkg::*;
#(
   parameter int HOLD_CYCLES = 100,
   parameter int GATE_OP     = GATE_OR,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [1:0] vec_idx,
   output logic [1:0] fail_vec
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       vec_q;
   logic [2:0]       err_q;
   logic             pass_q;
   logic             exp_y, last_cycle, mismatch, cmp_en, start_acc;

   gate_ref_model #(.GATE_OP(GATE_OP)) u_ref (
      .a     (vec_q[1]),
      .b     (vec_q[0]),
      .exp_y (exp_y)
   );

   assign last_cycle = (cnt == CNT_W'(HOLD_CYCLES - 1));
   // Case inequality so an X/Z on y counts as a miss in simulation.
   assign mismatch   = (y !== exp_y);
   assign cmp_en     = (state == ST_DRIVE) && last_cycle;
   assign start_acc  = (state == ST_IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_DRIVE;
         ST_DRIVE: if (last_cycle && vec_q == 2'd3) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         vec_q  <= 2'd0;
         err_q  <= 3'd0;
         pass_q <= 1'b0;
      end else if (start_acc) begin
         cnt    <= '0;
         vec_q  <= 2'd0;
         err_q  <= 3'd0;
         pass_q <= 1'b0;
      end else if (state == ST_DRIVE) begin
         if (cmp_en) begin
            cnt <= '0;
            if (mismatch) err_q <= err_q + 3'd1;
            // Last vector: pass must include this compare since err_q lags a cycle.
            if (vec_q == 2'd3) pass_q <= (err_q == 3'd0) && !mismatch;
            else               vec_q  <= vec_q + 2'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
   logic [1:0] fail_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     fail_q <= 2'd0;
      else if (start_acc)                          fail_q <= 2'd0;
      else if (cmp_en && mismatch && err_q == 3'd0) fail_q <= vec_q;
   end

   assign fail_vec = fail_q;
`else
   assign fail_vec = 2'd0;
`endif

   assign a         = vec_q[1];
   assign b         = vec_q[0];
   assign vec_idx   = vec_q;
   assign err_count = err_q;
   assign pass      = pass_q;
   assign busy      = (state == ST_DRIVE);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: four exercisers (OR ok, AND-vs-OR, stuck-1-vs-NOR, XOR hold=1)
// share clk/rst/start; table-driven timing checks plus restart/reset sequences.
module tb_gate_exerciser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] y_o, a_o, b_o, busy_o, done_o, pass_o;
   logic [2:0] err_o [4];
   logic [1:0] vec_o [4];
   logic [1:0] fv_o  [4];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   assign y_o[0] = a_o[0] | b_o[0];
   assign y_o[1] = a_o[1] & b_o[1];
   assign y_o[2] = 1'b1;
   assign y_o[3] = a_o[3] ^ b_o[3];

   gate_exerciser #(.HOLD_CYCLES(4), .GATE_OP(1), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .start(start), .y(y_o[0]), .a(a_o[0]), .b(b_o[0]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
      .vec_idx(vec_o[0]), .fail_vec(fv_o[0]));
   gate_exerciser #(.HOLD_CYCLES(4), .GATE_OP(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(start), .y(y_o[1]), .a(a_o[1]), .b(b_o[1]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
      .vec_idx(vec_o[1]), .fail_vec(fv_o[1]));
   gate_exerciser #(.HOLD_CYCLES(4), .GATE_OP(4), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .start(start), .y(y_o[2]), .a(a_o[2]), .b(b_o[2]),
      .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_o[2]),
      .vec_idx(vec_o[2]), .fail_vec(fv_o[2]));
   gate_exerciser #(.HOLD_CYCLES(1), .GATE_OP(2), .CNT_W(4)) u3 (
      .clk(clk), .rst(rst), .start(start), .y(y_o[3]), .a(a_o[3]), .b(b_o[3]),
      .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]), .err_count(err_o[3]),
      .vec_idx(vec_o[3]), .fail_vec(fv_o[3]));

   typedef struct {
      int         off;
      logic [1:0] v0;  logic bz0; logic dn0;
      logic [1:0] v3;  logic bz3; logic dn3;
   } row_t;

   typedef struct {
      logic [2:0] err;
      logic       pass;
      logic [1:0] fv;
   } res_t;

   row_t rows [11];
   res_t res  [4];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int snap(input int i);
      return {a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], vec_o[i], fv_o[i]};
   endfunction

   initial begin
      int cur;
      int dn;
      logic [1:0] fv_first;
`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
      fv_first = 2'd1;
`else
      fv_first = 2'd0;
`endif
      // offset = cycles after the start-accepting edge
      rows[0]  = '{0,  2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
      rows[1]  = '{1,  2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
      rows[2]  = '{3,  2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
      rows[3]  = '{4,  2'd1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
      rows[4]  = '{5,  2'd1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      rows[5]  = '{7,  2'd1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      rows[6]  = '{8,  2'd2, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      rows[7]  = '{12, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      rows[8]  = '{15, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
      rows[9]  = '{16, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
      rows[10] = '{17, 2'd3, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
      res[0] = '{3'd0, 1'b1, 2'd0};
      res[1] = '{3'd2, 1'b0, fv_first};
      res[2] = '{3'd3, 1'b0, fv_first};
      res[3] = '{3'd0, 1'b1, 2'd0};

      // Reset state
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("reset_u%0d", i), snap(i), 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Run 1: table-driven timing
      start = 1'b1;
      tick();
      start = 1'b0;
      cur = 0;
      for (int r = 0; r < 11; r++) begin
         while (cur < rows[r].off) begin tick(); cur++; end
         chk($sformatf("ab0@%0d", cur),   {a_o[0], b_o[0]}, rows[r].v0);
         chk($sformatf("vec0@%0d", cur),  vec_o[0],         rows[r].v0);
         chk($sformatf("busy0@%0d", cur), busy_o[0],        rows[r].bz0);
         chk($sformatf("done0@%0d", cur), done_o[0],        rows[r].dn0);
         chk($sformatf("ab3@%0d", cur),   {a_o[3], b_o[3]}, rows[r].v3);
         chk($sformatf("vec3@%0d", cur),  vec_o[3],         rows[r].v3);
         chk($sformatf("busy3@%0d", cur), busy_o[3],        rows[r].bz3);
         chk($sformatf("done3@%0d", cur), done_o[3],        rows[r].dn3);
         if (rows[r].dn0) chk("pass0_with_done", pass_o[0], 1);
         if (rows[r].dn3) chk("pass3_with_done", pass_o[3], 1);
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("err_u%0d", i),  err_o[i],  res[i].err);
         chk($sformatf("pass_u%0d", i), pass_o[i], res[i].pass);
         chk($sformatf("fv_u%0d", i),   fv_o[i],   res[i].fv);
      end

      // Run 2: ignored start pulses mid-run and during done
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err1_cleared_on_start", err_o[1], 0);
      chk("pass1_cleared_on_start", pass_o[1], 0);
      dn = 0;
      for (int k = 0; k < 24; k++) begin
         start = (k == 6) || (k == 16);
         tick();
         if (done_o[1]) dn++;
         if (k + 1 == 9) begin
            chk("vec1_not_restarted", vec_o[1], 2);
            chk("err1_not_cleared", err_o[1], 1);
         end
      end
      start = 1'b0;
      chk("done1_count", dn, 1);
      chk("err1_run2", err_o[1], 2);
      chk("fv1_run2", fv_o[1], fv_first);

      // Run 3: async reset during vector 2, then a clean run
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      chk("vec0_before_rst", vec_o[0], 2);
      chk("err1_before_rst", err_o[1], 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_u0", snap(0), 0);
      chk("rst_async_u1", snap(1), 0);
      tick();
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (done_o[0]) dn++; end
      chk("no_done_after_rst", dn, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      dn = 0;
      for (int k = 0; k < 18; k++) begin
         tick();
         if (done_o[0]) dn++;
         if (k + 1 == 16) chk("done0_latency_rerun", done_o[0], 1);
      end
      chk("done0_count_rerun", dn, 1);
      chk("pass0_rerun", pass_o[0], 1);
      chk("err0_rerun", err_o[0], 0);
      chk("err1_rerun", err_o[1], 2);
      chk("err2_rerun", err_o[2], 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
